// File: rtl/btn_event_gen.sv
//==============================================================================
// btn_event_gen -- two-button sync/debounce/edge-detect with busy-gated events
// Rev 1.0
//==============================================================================
`default_nettype none

module btn_event_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_move_raw,
  input  logic btn_select_raw,
  input  logic busy,
  output logic move,
  output logic select,
  output logic move_held,
  output logic select_held,
  output logic overrun
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel 0 is move, channel 1 is select.
  logic [1:0] raw;
  logic [1:0] held;
  logic [1:0] detect;
  logic [1:0] pend;
  logic [1:0] pend_next;
  logic [1:0] issue;

  assign raw = {btn_select_raw, btn_move_raw};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_ch
      logic          sync1;
      logic          sync2;
      logic          level;
      logic          pressed;
      logic [CW-1:0] cnt;

      assign pressed   = sync2 ^ ACTIVE_LOW;
      assign held[i]   = level;
      // Only the press edge of the debounced level is an event.
      assign detect[i] = (pressed != level) && (cnt == CNT_LAST) && !level;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1 <= ACTIVE_LOW;
          sync2 <= ACTIVE_LOW;
          cnt   <= '0;
          level <= 1'b0;
        end else begin
          sync1 <= raw[i];
          sync2 <= sync1;
          if (pressed == level) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= ~level;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    issue     = 2'b00;
    issue[1]  = !busy && pend[1];
    issue[0]  = !busy && !pend[1] && pend[0];
    // A detection while an event is already queued is dropped, not merged.
    pend_next = (detect & ~pend) | (pend & ~issue);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 2'b00;
      move    <= 1'b0;
      select  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pend    <= pend_next;
      move    <= issue[0];
      select  <= issue[1];
      overrun <= overrun | (|(detect & pend));
    end
  end

  assign move_held   = held[0];
  assign select_held = held[1];

endmodule

`default_nettype wire

// File: tb/tb_btn_event_gen.sv
//==============================================================================
// tb_btn_event_gen -- table, directed and random checks against a sample-window model
// Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_btn_event_gen;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_move_raw = 1'b1;
  logic btn_select_raw = 1'b1;
  logic busy = 1'b0;
  logic move, select, move_held, select_held, overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_no  = 0;

  always #5 clk = ~clk;

  btn_event_gen #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_move_raw  (btn_move_raw),
    .btn_select_raw(btn_select_raw),
    .busy          (busy),
    .move          (move),
    .select        (select),
    .move_held     (move_held),
    .select_held   (select_held),
    .overrun       (overrun)
  );

  // Reference model: pressed samples travel through a 2-deep delay line; a level
  // flips once D samples in a row since the last flip disagree with it.
  bit pipe [2][$];
  bit win  [2][$];
  bit lvl  [2];
  bit pend [2];
  bit ovr, e_move, e_sel;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      pipe[ch] = {1'b0, 1'b0};
      win[ch].delete();
      lvl[ch]  = 1'b0;
      pend[ch] = 1'b0;
    end
    ovr = 1'b0; e_move = 1'b0; e_sel = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit mr, input bit sr, input bit bz);
    bit raw [2];
    bit det [2];
    bit pre [2];
    bit s;
    if (r) begin
      model_reset();
      return;
    end
    raw[0] = mr; raw[1] = sr;
    for (int ch = 0; ch < 2; ch++) begin
      det[ch] = 1'b0;
      s = pipe[ch].pop_front();
      pipe[ch].push_back(~raw[ch]);
      if (s == lvl[ch]) win[ch].delete();
      else begin
        win[ch].push_back(s);
        if (win[ch].size() == D) begin
          lvl[ch] = s;
          win[ch].delete();
          det[ch] = s;
        end
      end
    end
    pre    = pend;
    e_sel  = !bz && pre[1];
    e_move = !bz && !pre[1] && pre[0];
    if (e_sel)  pend[1] = 1'b0;
    if (e_move) pend[0] = 1'b0;
    for (int ch = 0; ch < 2; ch++)
      if (det[ch]) begin
        if (pre[ch]) ovr = 1'b1;
        else pend[ch] = 1'b1;
      end
  endtask

  task automatic tick(input bit r, input bit mr, input bit sr, input bit bz);
    @(negedge clk);
    rst = r; btn_move_raw = mr; btn_select_raw = sr; busy = bz;
    model_step(r, mr, sr, bz);
    @(posedge clk);
    #1;
    tick_no++;
    check($sformatf("model@%0d", tick_no),
          {27'd0, move, select, move_held, select_held, overrun},
          {27'd0, e_move, e_sel, lvl[0], lvl[1], ovr});
  endtask

  typedef struct {
    bit rst; bit mr; bit sr; bit bz; int cycles;
    int n_move; int n_sel; bit ovr; bit mh; bit sh;
  } seg_t;

  seg_t tbl [13];

  initial begin
    int first_a, first_b, cnt_a, cnt_b, both;
    bit mr, sr, bz, r;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0,  2, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 50, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 30, 1, 0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 20, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 20, 1, 1, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 20, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 20, 0, 0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 20, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 20, 0, 0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 20, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0,  1, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b0, 1'b0};

    model_reset();

    for (int i = 0; i < 13; i++) begin
      cnt_a = 0; cnt_b = 0;
      for (int c = 0; c < tbl[i].cycles; c++) begin
        tick(tbl[i].rst, tbl[i].mr, tbl[i].sr, tbl[i].bz);
        if (move === 1'b1)   cnt_a++;
        if (select === 1'b1) cnt_b++;
      end
      check($sformatf("seg%0d move_pulses", i), cnt_a, tbl[i].n_move);
      check($sformatf("seg%0d select_pulses", i), cnt_b, tbl[i].n_sel);
      check($sformatf("seg%0d ovr_mh_sh", i), {29'd0, overrun, move_held, select_held},
            {29'd0, tbl[i].ovr, tbl[i].mh, tbl[i].sh});
    end

    // Clean press: level after k+5, pulse only after k+6.
    for (int j = 0; j < 10; j++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("latency held j%0d", j), move_held, (j >= 5));
      check($sformatf("latency pulse j%0d", j), move, (j == 6));
    end
    for (int j = 0; j < 20; j++) tick(1'b0, 1'b1, 1'b1, 1'b0);

    // Bounce on select: low 3, high 2, then low for good.
    cnt_b = 0; first_b = -1; cnt_a = 0;
    for (int j = 0; j < 20; j++) begin
      tick(1'b0, 1'b1, (j >= 3 && j < 5), 1'b0);
      if (select === 1'b1) begin cnt_b++; if (first_b < 0) first_b = j; end
      if (move === 1'b1) cnt_a++;
    end
    check("bounce select_pulses", cnt_b, 1);
    check("bounce pulse_index", first_b, 11);
    check("bounce move_pulses", cnt_a, 0);
    for (int j = 0; j < 20; j++) tick(1'b0, 1'b1, 1'b1, 1'b0);

    // Simultaneous presses: select first, move next cycle.
    first_a = -1; first_b = -1; both = 0;
    for (int j = 0; j < 12; j++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (move === 1'b1 && first_a < 0)   first_a = j;
      if (select === 1'b1 && first_b < 0) first_b = j;
      if (move === 1'b1 && select === 1'b1) both++;
    end
    check("simul select_index", first_b, 6);
    check("simul move_index", first_a, 7);
    check("simul overlap", both, 0);
    for (int j = 0; j < 20; j++) tick(1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-debounce with the button held throughout: old press discarded,
    // count restarts, pulse comes at the post-reset latency.
    cnt_a = 0; first_a = -1;
    for (int j = 0; j < 15; j++) begin
      tick((j == 4), 1'b0, 1'b1, 1'b0);
      if (move === 1'b1) begin cnt_a++; if (first_a < 0) first_a = j; end
    end
    check("rst_mid move_pulses", cnt_a, 1);
    check("rst_mid pulse_index", first_a, 11);
    check("rst_mid overrun", overrun, 1'b0);
    for (int j = 0; j < 20; j++) tick(1'b0, 1'b1, 1'b1, 1'b0);

    // Random traffic against the model.
    mr = 1'b1; sr = 1'b1; bz = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(11) == 0) mr = ~mr;
      if ($urandom_range(11) == 0) sr = ~sr;
      if ($urandom_range(5) == 0)  bz = ~bz;
      r = ($urandom_range(499) == 0);
      tick(r, mr, sr, bz);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
